// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-to-one fetch/data arbiter onto a single memory port.
// Define MEM_BUS_ARB_RR_EN for round-robin ties; otherwise data wins ties.
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_addr_ok,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,
    output logic        mreq_valid,
    output logic        mreq_is_write,
    output logic [63:0] mreq_addr,
    output logic [2:0]  mreq_size,
    output logic [7:0]  mreq_strobe,
    output logic [63:0] mreq_data,
    input  logic        mresp_ready,
    input  logic        mresp_last,
    input  logic [63:0] mresp_data
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    state_t      state;
    logic        grant_d;
    logic        done;
    logic        req_is_write;
    logic [63:0] req_addr;
    logic [2:0]  req_size;
    logic [7:0]  req_strobe;
    logic [63:0] req_data;
    assign done = mresp_ready & mresp_last;
`ifdef MEM_BUS_ARB_RR_EN
    logic last_grant;
    assign grant_d = dreq_valid & (~ireq_valid | ~last_grant);
    always_ff @(posedge clk or posedge reset)
        if (reset)
            last_grant <= 1'b0;
        else if (state != IDLE && done)
            last_grant <= state == BUSY_D;
`else
    assign grant_d = dreq_valid;
`endif
    // The request register is only loaded in IDLE, which locks it until the last beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            req_is_write <= 1'b0;
            req_addr     <= '0;
            req_size     <= '0;
            req_strobe   <= '0;
            req_data     <= '0;
        end else begin
            case (state)
                IDLE: if (ireq_valid | dreq_valid) begin
                    state        <= grant_d ? BUSY_D : BUSY_I;
                    req_is_write <= grant_d ? |dreq_strobe : 1'b0;
                    req_addr     <= grant_d ? dreq_addr : ireq_addr;
                    req_size     <= grant_d ? dreq_size : 3'b010;
                    req_strobe   <= grant_d ? dreq_strobe : 8'h00;
                    req_data     <= grant_d ? dreq_data : 64'h0;
                end
                BUSY_I, BUSY_D: if (done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign mreq_valid    = state != IDLE;
    assign mreq_is_write = req_is_write;
    assign mreq_addr     = req_addr;
    assign mreq_size     = req_size;
    assign mreq_strobe   = req_strobe;
    assign mreq_data     = req_data;
    assign iresp_data_ok = state == BUSY_I && done;
    assign dresp_data_ok = state == BUSY_D && done;
    assign iresp_addr_ok = iresp_data_ok;
    assign dresp_addr_ok = dresp_data_ok;
    assign iresp_data    = !iresp_data_ok ? 32'h0 : req_addr[2] ? mresp_data[63:32] : mresp_data[31:0];
    assign dresp_data    = dresp_data_ok ? mresp_data : 64'h0;
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-to-one memory-bus arbiter between the core's instruction-fetch port and data port and the single downstream memory port. It grants one requester at a time, latches that requester's request, and holds it on the memory port until the final response beat. It then returns the response to the granted requester on that requester's own addr_ok/data_ok handshake. It sits between `core` and the memory/cache interconnect in the top-level wrapper.

## Interface
Parameters:
- none; all widths are fixed by the bus types below.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ireq_valid  in  1  fetch request valid; held by the requester until iresp_data_ok.
- ireq_addr  in  64  fetch address, 4-byte aligned.
- iresp_addr_ok  out  1  fetch address accepted; single-cycle pulse.
- iresp_data_ok  out  1  fetch data valid; single-cycle pulse.
- iresp_data  out  32  fetched instruction.
- dreq_valid  in  1  data request valid; held by the requester until dresp_data_ok.
- dreq_addr  in  64  data address.
- dreq_size  in  3  log2 of the access size in bytes.
- dreq_strobe  in  8  byte write enables; 0 means a read.
- dreq_data  in  64  store data.
- dresp_addr_ok  out  1  data address accepted; single-cycle pulse.
- dresp_data_ok  out  1  data response valid; single-cycle pulse.
- dresp_data  out  64  load data.
- mreq_valid  out  1  memory request valid.
- mreq_is_write  out  1  write transaction.
- mreq_addr  out  64  memory address.
- mreq_size  out  3  access size.
- mreq_strobe  out  8  byte enables.
- mreq_data  out  64  write data.
- mresp_ready  in  1  memory response beat valid.
- mresp_last  in  1  final beat of the transaction.
- mresp_data  in  64  memory read data.

## Operation
FSM states:
- IDLE
  - If ireq_valid or dreq_valid is set, the winner's request is latched into an internal request register.
  - Winner is I → go to BUSY_I. Winner is D → go to BUSY_D.
  - No request → stay in IDLE.
- BUSY_I / BUSY_D
  - mreq_* is driven from the request register; mreq_valid = 1.
  - On mresp_ready & mresp_last:
    - pulse the granted requester's addr_ok and data_ok together;
    - update last_grant;
    - go to IDLE.
  - mresp_ready without mresp_last: the beat is ignored and the state holds.

Request formation:
- Fetch request: is_write = 0, size = 3'b010, strobe = 0, data = 0, addr = ireq_addr.
- Data request: is_write = |dreq_strobe; the other fields are copied from dreq_*.

Response data:
- iresp_data = ireq_addr_latched[2] ? mresp_data[63:32] : mresp_data[31:0].
- dresp_data = mresp_data, passed through unmodified.
- Both response data outputs are 0 whenever their data_ok is low.

Arbitration and boundary rules:
- Once granted, a request is locked. Changes on the requester's inputs, including dropping valid, are ignored until completion, and the data_ok pulse is still delivered.
- The non-granted requester sees addr_ok = data_ok = 0 for as long as it waits.
- A new request presented in the cycle after completion is arbitrated normally in IDLE.

## Timing
- Reset (asynchronous):
  - state = IDLE, request register = 0, last_grant = I;
  - all outputs are 0 while reset is asserted and in the first cycle after reset.
- Reset asserted mid-transaction: the transaction is abandoned and no data_ok is issued.
- Request seen in IDLE in cycle N:
  - request latched at the edge ending cycle N;
  - mreq_valid = 1 from cycle N+1.
- Response:
  - data_ok is combinational in the cycle where mresp_ready & mresp_last holds; minimum request-to-data_ok latency is 1 cycle (memory answering in cycle N+1).
  - mreq_valid drops in the cycle after the last beat. There is exactly one IDLE cycle between back-to-back transactions.
- mreq_* fields are stable for the whole time mreq_valid is high.

## Configuration
Macro: `MEM_BUS_ARB_RR_EN`.
- Defined (round-robin): when both requesters are valid in IDLE, grant goes to the requester not named by last_grant.
- Undefined (fixed priority): data always wins a tie and last_grant is unused. Rationale: a stalled memory stage must never wait behind fetch.
- A single valid request is granted immediately in both modes.

## Test plan
- Single fetch:
  - stimulus: ireq_addr = 0x8000_0004; memory returns mresp_data = 0x1111_2222_3333_4444 with last, 2 cycles after mreq_valid rises.
  - required: iresp_data = 0x1111_2222; mreq_size = 2; mreq_is_write = 0.
- Data store:
  - stimulus: dreq_addr = 0x8000_0010, strobe = 0x0F, data = 0xDEAD_BEEF.
  - required: mreq_is_write = 1 and mreq_strobe = 0x0F, stable until last; then one dresp_data_ok pulse.
- Tie:
  - stimulus: both requesters valid from reset.
  - required with macro: D then I then D alternation. Required without macro: D granted first, and D is granted again whenever both are valid.
- Multi-beat:
  - stimulus: 4 mresp_ready beats, last on beat 4.
  - required: exactly one data_ok pulse, on beat 4, carrying beat 4's data.
- Withdrawal:
  - stimulus: ireq_valid dropped 1 cycle after the grant.
  - required: the transaction completes and iresp_data_ok still pulses once.
- Reset:
  - stimulus: reset asserted in BUSY_D.
  - required: mreq_valid = 0 immediately; no dresp_data_ok is issued; the next request is served normally.
